// File: rtl/mem_stage_sram_if.sv
// Pipeline-side bundle of the MEM stage: EXE/MEM inputs, stall output and MEM/WB register outputs.
interface mem_stage_sram_if;
   logic        wb_en_in;
   logic        mem_r_en_in;
   logic        mem_w_en_in;
   logic [31:0] alu_result_in;
   logic [31:0] st_val_in;
   logic [31:0] dest_in;
   logic        ready;
   logic        wb_en;
   logic        mem_r_en;
   logic [31:0] alu_result;
   logic [31:0] mem_result;
   logic [31:0] dest;

   modport master (
      output wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, st_val_in, dest_in,
      input  ready, wb_en, mem_r_en, alu_result, mem_result, dest
   );

   modport slave (
      input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, st_val_in, dest_in,
      output ready, wb_en, mem_r_en, alu_result, mem_result, dest
   );
endinterface

// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit loads/stores as two half-word accesses on a 16-bit async SRAM,
// stalling the upstream pipeline while busy, followed by the MEM/WB pipeline register.
module mem_stage_sram #(
   parameter int unsigned BASE_ADDR     = 1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   mem_stage_sram_if.slave   bus,
   output logic [17:0]       sram_addr,
   inout  wire  [15:0]       sram_dq,
   output logic              sram_we_n,
   output logic              sram_oe_n,
   output logic              sram_ce_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WORD_W = 17;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, LO, HI, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q;
   logic [WORD_W-1:0]   word_q;
   logic [31:0]         st_q;
   logic [15:0]         lo_q, hi_q;

   logic                wb_en_q, mem_r_en_q;
   logic [31:0]         alu_result_q, mem_result_q, dest_q;

   logic                req_c, last_c, access_c, is_hi_c, ready_c;
   logic [WORD_W-1:0]   word_c;

   assign req_c    = bus.mem_r_en_in | bus.mem_w_en_in;
   assign word_c   = WORD_W'((bus.alu_result_in - 32'(BASE_ADDR)) >> 2);
   assign last_c   = (cnt_q == LAST);
   assign access_c = rst && ((state_q == LO) || (state_q == HI));
   assign is_hi_c  = (state_q == HI);
   assign ready_c  = !rst || ((state_q == IDLE) && !req_c) || (state_q == DONE);

   // SRAM pins decode straight from the state register; reset releases the bus at once.
   assign sram_ce_n = 1'b0;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;
   assign sram_addr = access_c ? {word_q, is_hi_c} : 18'd0;
   assign sram_oe_n = !(access_c && !wr_q);
   assign sram_we_n = !(access_c && wr_q && (!last_c || (ACCESS_CYCLES == 32'd1)));
   assign sram_dq   = (access_c && wr_q) ? (is_hi_c ? st_q[31:16] : st_q[15:0]) : 16'bz;

   // Next-state and access counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:  if (req_c) state_d = SETUP;
         SETUP: begin
            state_d = LO;
            cnt_d   = '0;
         end
         LO: begin
            if (last_c) begin
               state_d = HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HI: begin
            if (last_c) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, operation latch and read-data capture
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         word_q  <= '0;
         st_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == SETUP) begin
            wr_q   <= bus.mem_w_en_in;
            word_q <= word_c;
            st_q   <= bus.st_val_in;
         end
         if ((state_q == LO) && last_c && !wr_q) lo_q <= sram_dq;
         if ((state_q == HI) && last_c && !wr_q) hi_q <= sram_dq;
      end
   end

   // MEM/WB register: advances with the pipeline, inserts a bubble while stalled
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_en_q      <= 1'b0;
         mem_r_en_q   <= 1'b0;
         alu_result_q <= '0;
         mem_result_q <= '0;
         dest_q       <= '0;
      end else if (ready_c) begin
         wb_en_q      <= bus.wb_en_in;
         mem_r_en_q   <= bus.mem_r_en_in;
         alu_result_q <= bus.alu_result_in;
         dest_q       <= bus.dest_in;
         mem_result_q <= ((state_q == DONE) && !wr_q) ? {hi_q, lo_q} : 32'd0;
      end else begin
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
      end
   end

   assign bus.ready      = ready_c;
   assign bus.wb_en      = wb_en_q;
   assign bus.mem_r_en   = mem_r_en_q;
   assign bus.alu_result = alu_result_q;
   assign bus.mem_result = mem_result_q;
   assign bus.dest       = dest_q;
endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: per-cycle compare against a timeline model plus literal spot checks.
module tb_mem_stage_sram;
   localparam int BASE = 1024;
   localparam int AC   = 2;
   localparam int NOP  = -1;

   logic        clk;
   logic        rst;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   mem_stage_sram_if bus ();

   mem_stage_sram #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sram_addr(sram_addr), .sram_dq(sram_dq),
      .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External SRAM: drives the bus while OE is low, stores on WE low at the clock edge.
   logic [15:0] sram_mem [0:262143];
   assign sram_dq = sram_oe_n ? 16'bz : sram_mem[sram_addr];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected values for the current cycle, set by the stimulus tasks
   logic        chk_en = 1'b0;
   logic        exp_ready, exp_oe_n, exp_we_n, exp_drv;
   logic [17:0] exp_addr;
   logic [15:0] exp_dq;
   logic [31:0] cur_mres;
   logic [31:0] ref_mem [int unsigned];

   // MEM/WB model: pipeline advances on ready, bubble otherwise
   logic        m_wb, m_mr;
   logic [31:0] m_alu, m_mres, m_dest;
   always @(posedge clk) begin
      if (!rst) begin
         m_wb <= 1'b0; m_mr <= 1'b0; m_alu <= '0; m_mres <= '0; m_dest <= '0;
      end else if (exp_ready) begin
         m_wb   <= bus.wb_en_in;
         m_mr   <= bus.mem_r_en_in;
         m_alu  <= bus.alu_result_in;
         m_dest <= bus.dest_in;
         m_mres <= cur_mres;
      end else begin
         m_wb <= 1'b0; m_mr <= 1'b0;
      end
   end

   int we_cnt, oe_cnt, rdy_low;
   logic [17:0] oe_addrs [$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", 32'(bus.ready), 32'(exp_ready));
         chk("sram_oe_n", 32'(sram_oe_n), 32'(exp_oe_n));
         chk("sram_we_n", 32'(sram_we_n), 32'(exp_we_n));
         chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
         chk("fixed_strobes", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
         if (exp_drv) chk("sram_dq", 32'(sram_dq), 32'(exp_dq));
         chk("wb_en", 32'(bus.wb_en), 32'(m_wb));
         chk("mem_r_en", 32'(bus.mem_r_en), 32'(m_mr));
         chk("alu_result", bus.alu_result, m_alu);
         chk("mem_result", bus.mem_result, m_mres);
         chk("dest", bus.dest, m_dest);
         if (!sram_we_n) we_cnt++;
         if (!sram_oe_n) begin oe_cnt++; oe_addrs.push_back(sram_addr); end
         if (!bus.ready) rdy_low++;
      end
   end

   task automatic bus_idle();
      exp_oe_n = 1'b1; exp_we_n = 1'b1; exp_drv = 1'b0; exp_addr = '0; exp_dq = '0;
   endtask

   task automatic nop(input logic [31:0] alu, input logic [31:0] dst, input logic wb);
      bus.wb_en_in = wb; bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0;
      bus.alu_result_in = alu; bus.st_val_in = '0; bus.dest_in = dst;
      exp_ready = 1'b1; cur_mres = '0; bus_idle();
      @(posedge clk); #1;
   endtask

   // A memory op presented in IDLE: request cycle, SETUP, AC low-half cycles, AC high-half cycles, DONE.
   task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] st, input logic [31:0] dst, input logic wb,
                         input int abort_p);
      logic [16:0] w;
      int half, sub;
      w = 17'((addr - 32'(BASE)) >> 2);
      bus.wb_en_in = wb; bus.mem_r_en_in = rd; bus.mem_w_en_in = wr;
      bus.alu_result_in = addr; bus.st_val_in = st; bus.dest_in = dst;
      for (int p = 0; p <= 2*AC+2; p++) begin
         if (p == abort_p) begin
            rst = 1'b0; exp_ready = 1'b1; cur_mres = '0; bus_idle();
            @(posedge clk); #1;
            chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
            chk("rst_alu_result", bus.alu_result, 32'd0);
            chk("rst_dest", bus.dest, 32'd0);
            chk("rst_mem_result", bus.mem_result, 32'd0);
            rst = 1'b1;
            nop(32'd0, 32'd0, 1'b0);
            return;
         end
         exp_ready = (p == 2*AC+2);
         cur_mres = (exp_ready && rd && !wr) ? ref_mem[32'(w)] : 32'd0;
         bus_idle();
         if (p >= 2 && p <= 2*AC+1) begin
            half = (p-2) / AC;
            sub  = (p-2) % AC;
            exp_addr = {w, 1'(half)};
            if (wr) begin
               exp_drv  = 1'b1;
               exp_dq   = (half == 1) ? st[31:16] : st[15:0];
               exp_we_n = (AC == 1) ? 1'b0 : (sub == AC-1);
            end else begin
               exp_oe_n = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      if (wr) ref_mem[32'(w)] = st;
   endtask

   task automatic clr_counts();
      we_cnt = 0; oe_cnt = 0; rdy_low = 0; oe_addrs.delete();
   endtask

   initial begin
      for (int i = 0; i < 262144; i++) sram_mem[i] = '0;
      rst = 1'b0;
      bus.wb_en_in = 1'b0; bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0;
      bus.alu_result_in = '0; bus.st_val_in = '0; bus.dest_in = '0;
      exp_ready = 1'b1; cur_mres = '0; bus_idle();
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk("reset_ready", 32'(bus.ready), 32'd1);
      chk("reset_mem_result", bus.mem_result, 32'd0);
      rst = 1'b1;

      // Non-memory instruction
      clr_counts();
      nop(32'h1234, 32'd5, 1'b1);
      chk("nop_wb_en", 32'(bus.wb_en), 32'd1);
      chk("nop_alu_result", bus.alu_result, 32'h1234);
      chk("nop_mem_r_en", 32'(bus.mem_r_en), 32'd0);
      chk("nop_strobes", 32'(we_cnt + oe_cnt + rdy_low), 32'd0);

      // Store 0xDEADBEEF at 1024+8: half-words 4 and 5
      clr_counts();
      mem_op(1'b0, 1'b1, 32'(BASE+8), 32'hDEADBEEF, 32'd0, 1'b0, NOP);
      chk("st_lo_word", 32'(sram_mem[4]), 32'h0000BEEF);
      chk("st_hi_word", 32'(sram_mem[5]), 32'h0000DEAD);
      chk("st_we_cycles", 32'(we_cnt), 32'd2);
      // request cycle in IDLE + SETUP + four access cycles
      chk("st_stall_cycles", 32'(rdy_low), 32'd6);

      // Load it back
      clr_counts();
      mem_op(1'b1, 1'b0, 32'(BASE+8), 32'd0, 32'd7, 1'b1, NOP);
      chk("ld_oe_cycles", 32'(oe_cnt), 32'd4);
      chk("ld_mem_result", bus.mem_result, 32'hDEADBEEF);
      chk("ld_mem_r_en", 32'(bus.mem_r_en), 32'd1);
      chk("ld_wb_en", 32'(bus.wb_en), 32'd1);
      nop(32'd0, 32'd0, 1'b0);

      // Back-to-back stores then back-to-back loads at 1024 and 1028
      mem_op(1'b0, 1'b1, 32'(BASE),   32'h11112222, 32'd0, 1'b0, NOP);
      mem_op(1'b0, 1'b1, 32'(BASE+4), 32'h33334444, 32'd0, 1'b0, NOP);
      clr_counts();
      mem_op(1'b1, 1'b0, 32'(BASE),   32'd0, 32'd8, 1'b1, NOP);
      chk("b2b_first_result", bus.mem_result, 32'h11112222);
      mem_op(1'b1, 1'b0, 32'(BASE+4), 32'd0, 32'd9, 1'b1, NOP);
      chk("b2b_second_result", bus.mem_result, 32'h33334444);
      chk("b2b_oe_count", 32'(oe_addrs.size()), 32'd8);
      if (oe_addrs.size() == 8) begin
         chk("b2b_addr_lo", 32'(oe_addrs[4]), 32'd2);
         chk("b2b_addr_hi", 32'(oe_addrs[6]), 32'd3);
      end
      chk("b2b_stall_cycles", 32'(rdy_low), 32'd12);

      // Both enables: treated as a write, address wraps to the last word
      mem_op(1'b1, 1'b1, 32'(BASE + 32'h7FFFC + 32'h80000), 32'hCAFEF00D, 32'd3, 1'b0, NOP);
      chk("wrap_lo", 32'(sram_mem[18'h3FFFE]), 32'h0000F00D);
      chk("wrap_hi", 32'(sram_mem[18'h3FFFF]), 32'h0000CAFE);
      chk("wrap_mem_result", bus.mem_result, 32'd0);

      // Reset during the first high-half cycle of a store to 1024+16
      mem_op(1'b0, 1'b1, 32'(BASE+16), 32'hA5A55A5A, 32'd0, 1'b0, 2+AC);
      chk("abort_hi_unwritten", 32'(sram_mem[9]), 32'd0);
      chk("abort_ready", 32'(bus.ready), 32'd1);
      mem_op(1'b1, 1'b0, 32'(BASE+8), 32'd0, 32'd11, 1'b1, NOP);
      chk("post_rst_load", bus.mem_result, 32'hDEADBEEF);
      nop(32'd0, 32'd0, 1'b0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
